// File: rtl/auto_baud_detect.sv
// Measures an rx start-bit width and returns the matching BaudVal code; done/error pulse 2 clk after the pulse ends (+2 sync).
// No backpressure: arm is only accepted in IDLE. Define AUTOBAUD_AVG_EN to average two low pulses (0x55 start bit + bit1).
module auto_baud_detect #(
   parameter int         MAX_COUNT    = 500000,
   parameter int         MIN_COUNT    = 55,
   parameter int         IDLE_CYCLES  = 1024,
   parameter logic [3:0] DEFAULT_BAUD = 4'b1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   input  logic       arm,
   output logic [3:0] baud_val,
   output logic       done,
   output logic       error,
   output logic       busy
);

   localparam int              IW     = $clog2(IDLE_CYCLES + 1);
   localparam logic [IW-1:0]   IDLE_N = IW'(IDLE_CYCLES);
   localparam logic [18:0]     SAT    = 19'(MAX_COUNT + 1);
   localparam logic [19:0]     MAX20  = 20'(MAX_COUNT);
   localparam logic [19:0]     MIN20  = 20'(MIN_COUNT);

   typedef enum logic [3:0] {
      S_IDLE,
      S_WAIT_IDLE,
      S_WAIT_START,
      S_MEASURE,
`ifdef AUTOBAUD_AVG_EN
      S_GAP,
      S_MEASURE2,
`endif
      S_CLASSIFY,
      S_DONE,
      S_FAIL,
      S_WAIT_HIGH
   } state_t;

   state_t        state_q, state_d;
   logic          rx_meta_q, rxs_q;
   logic [IW-1:0] idle_q, idle_d;
   logic [18:0]   cnt_q, cnt_d;
   logic [3:0]    baud_q, baud_d;
   logic          done_q, done_d;
   logic          error_q, error_d;
   logic          busy_q, busy_d;
   logic [19:0]   meas;
`ifdef AUTOBAUD_AVG_EN
   logic [18:0]   cnt2_q, cnt2_d;
   logic [18:0]   gap_q, gap_d;
   logic [19:0]   sum;
`endif

   function automatic logic [3:0] classify(input logic [19:0] v);
      if (v >= 20'd208333)     return 4'd0;
      else if (v >= 20'd62500) return 4'd1;
      else if (v >= 20'd31250) return 4'd2;
      else if (v >= 20'd15625) return 4'd3;
      else if (v >= 20'd7812)  return 4'd4;
      else if (v >= 20'd3906)  return 4'd5;
      else if (v >= 20'd2170)  return 4'd6;
      else if (v >= 20'd1302)  return 4'd7;
      else if (v >= 20'd651)   return 4'd8;
      else if (v >= 20'd325)   return 4'd9;
      else if (v >= 20'd163)   return 4'd10;
      else                     return 4'd11;
   endfunction

   always_comb begin
`ifdef AUTOBAUD_AVG_EN
      sum  = {1'b0, cnt_q} + {1'b0, cnt2_q};
      meas = sum >> 1;
`else
      meas = {1'b0, cnt_q};
`endif
   end

   always_comb begin
      state_d = state_q;
      idle_d  = idle_q;
      cnt_d   = cnt_q;
      baud_d  = baud_q;
`ifdef AUTOBAUD_AVG_EN
      cnt2_d  = cnt2_q;
      gap_d   = gap_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (arm) begin
               state_d = S_WAIT_IDLE;
               idle_d  = '0;
            end
         end
         S_WAIT_IDLE: begin
            // any low sample restarts the quiet-line qualification
            if (!rxs_q) begin
               idle_d = '0;
            end else if (idle_q == IDLE_N - IW'(1)) begin
               idle_d  = '0;
               state_d = S_WAIT_START;
            end else begin
               idle_d = idle_q + IW'(1);
            end
         end
         S_WAIT_START: begin
            if (!rxs_q) begin
               cnt_d   = 19'd1;
               state_d = S_MEASURE;
            end
         end
         S_MEASURE: begin
            if (rxs_q) begin
`ifdef AUTOBAUD_AVG_EN
               gap_d   = 19'd1;
               state_d = S_GAP;
`else
               state_d = S_CLASSIFY;
`endif
            end else begin
               cnt_d = cnt_q + 19'd1;
               if (cnt_d == SAT) state_d = S_FAIL;
            end
         end
`ifdef AUTOBAUD_AVG_EN
         S_GAP: begin
            if (rxs_q) begin
               gap_d = gap_q + 19'd1;
               if (gap_d == SAT) state_d = S_FAIL;
            end else begin
               cnt2_d  = 19'd1;
               state_d = S_MEASURE2;
            end
         end
         S_MEASURE2: begin
            if (rxs_q) begin
               state_d = S_CLASSIFY;
            end else begin
               cnt2_d = cnt2_q + 19'd1;
               if (cnt2_d == SAT) state_d = S_FAIL;
            end
         end
`endif
         S_CLASSIFY: begin
            // code is loaded here so baud_val is already new while done is high
            if (meas >= MIN20 && meas <= MAX20) begin
               baud_d  = classify(meas);
               state_d = S_DONE;
            end else begin
               state_d = S_FAIL;
            end
         end
         S_DONE:      state_d = S_IDLE;
         S_FAIL:      state_d = S_WAIT_HIGH;
         S_WAIT_HIGH: if (rxs_q) state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase

      done_d  = (state_d == S_DONE);
      error_d = (state_d == S_FAIL);
      busy_d  = !(state_d inside {S_IDLE, S_DONE, S_FAIL, S_WAIT_HIGH});
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rxs_q     <= 1'b1;
         state_q   <= S_IDLE;
         idle_q    <= '0;
         cnt_q     <= '0;
         baud_q    <= DEFAULT_BAUD;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         busy_q    <= 1'b0;
`ifdef AUTOBAUD_AVG_EN
         cnt2_q    <= '0;
         gap_q     <= '0;
`endif
      end else begin
         rx_meta_q <= rx;
         rxs_q     <= rx_meta_q;
         state_q   <= state_d;
         idle_q    <= idle_d;
         cnt_q     <= cnt_d;
         baud_q    <= baud_d;
         done_q    <= done_d;
         error_q   <= error_d;
         busy_q    <= busy_d;
`ifdef AUTOBAUD_AVG_EN
         cnt2_q    <= cnt2_d;
         gap_q     <= gap_d;
`endif
      end
   end

   assign baud_val = baud_q;
   assign done     = done_q;
   assign error    = error_q;
   assign busy     = busy_q;

endmodule
